preg_free_list_ctrl: RTL and testbench

//  Manages the free physical-register list consumed by the rename stage. Grants up to

---
 rtl/preg_free_list_ctrl_pkg.sv | 12 +
 rtl/preg_free_list_ctrl_if.sv | 21 ++
 rtl/preg_free_list_ctrl_prefix_count.sv | 17 +
 rtl/preg_free_list_ctrl.sv | 59 +++++
 tb/tb_preg_free_list_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/preg_free_list_ctrl_pkg.sv
// preg_free_list_ctrl_pkg: sizes and types shared by the free-list controller, its interface and bench
package preg_free_list_ctrl_pkg;
  localparam int NUM_PREGS    = 128;
  localparam int NUM_AREGS    = 32;
  localparam int RENAME_WIDTH = 4;
  localparam int COMMIT_WIDTH = 4;
  localparam int PW           = $clog2(NUM_PREGS);
  localparam int AW           = $clog2(RENAME_WIDTH + 1);
  localparam int CW           = $clog2(COMMIT_WIDTH + 1);
  typedef logic [PW-1:0] preg_t;
  typedef logic [PW:0]   fl_ptr_t;
endpackage

// File: rtl/preg_free_list_ctrl_if.sv
// preg_free_list_ctrl_if: rename/commit-side bundle of the physical-register free list
interface preg_free_list_ctrl_if;
  import preg_free_list_ctrl_pkg::*;
  logic [RENAME_WIDTH-1:0]        alloc_req;
  logic                           alloc_ready;
  preg_t [RENAME_WIDTH-1:0]       alloc_preg;
  logic [COMMIT_WIDTH-1:0]        free_valid;
  preg_t [COMMIT_WIDTH-1:0]       free_preg;
  logic [CW-1:0]                  commit_alloc_cnt;
  logic                           flush;
  fl_ptr_t                        free_count;
  logic                           err;
  modport master (
    output alloc_req, free_valid, free_preg, commit_alloc_cnt, flush,
    input  alloc_ready, alloc_preg, free_count, err
  );
  modport slave (
    input  alloc_req, free_valid, free_preg, commit_alloc_cnt, flush,
    output alloc_ready, alloc_preg, free_count, err
  );
endinterface

// File: rtl/preg_free_list_ctrl_prefix_count.sv
// preg_free_list_ctrl_prefix_count: per-bit exclusive prefix popcount of a vector plus its total
module preg_free_list_ctrl_prefix_count #(
  parameter int W = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         i_vec,
  output logic [W-1:0][CW-1:0] o_pre,
  output logic [CW-1:0]        o_total
);
  always_comb begin
    o_total = '0;
    for (int i = 0; i < W; i++) begin
      o_pre[i] = o_total;
      o_total  = o_total + CW'(i_vec[i]);
    end
  end
endmodule

// File: rtl/preg_free_list_ctrl.sv
// preg_free_list_ctrl: circular free list of physical registers with speculative and architectural heads
module preg_free_list_ctrl
  import preg_free_list_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  preg_free_list_ctrl_if.slave fl
);
  preg_t   r_buf [NUM_PREGS];
  fl_ptr_t r_spec_head, r_arch_head, r_tail;
  logic    r_err;
  logic [RENAME_WIDTH-1:0][AW-1:0] w_a_pre;
  logic [AW-1:0]                   w_a_n;
  logic [COMMIT_WIDTH-1:0][CW-1:0] w_f_pre;
  logic [CW-1:0]                   w_f_n;
  fl_ptr_t w_free_count, w_inflight, w_arch_nxt;
  logic    w_fire, w_ovf, w_cerr;

  preg_free_list_ctrl_prefix_count #(.W(RENAME_WIDTH)) u_alloc_pc (
    .i_vec(fl.alloc_req), .o_pre(w_a_pre), .o_total(w_a_n)
  );
  preg_free_list_ctrl_prefix_count #(.W(COMMIT_WIDTH)) u_free_pc (
    .i_vec(fl.free_valid), .o_pre(w_f_pre), .o_total(w_f_n)
  );

  assign w_free_count   = r_tail - r_spec_head;
  assign w_inflight     = r_spec_head - r_arch_head;
  assign fl.alloc_ready = !fl.flush && (w_free_count >= fl_ptr_t'(w_a_n));
  assign w_fire         = fl.alloc_ready && (w_a_n != '0);
  assign w_ovf          = (w_free_count == fl_ptr_t'(NUM_PREGS)) && |fl.free_valid;
  assign w_cerr         = fl_ptr_t'(fl.commit_alloc_cnt) > w_inflight;
  // Over-commit clamps to the speculative head so the arch head never passes it.
  assign w_arch_nxt     = w_cerr ? r_spec_head : r_arch_head + fl_ptr_t'(fl.commit_alloc_cnt);
  assign fl.free_count  = w_free_count;
  assign fl.err         = r_err;

  for (genvar i = 0; i < RENAME_WIDTH; i++) begin : g_lane
    assign fl.alloc_preg[i] = r_buf[preg_t'(r_spec_head + fl_ptr_t'(w_a_pre[i]))];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_PREGS; k++)
        r_buf[k] <= (k < NUM_PREGS - NUM_AREGS) ? preg_t'(NUM_AREGS + k) : '0;
      r_spec_head <= '0;
      r_arch_head <= '0;
      r_tail      <= fl_ptr_t'(NUM_PREGS - NUM_AREGS);
      r_err       <= 1'b0;
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (fl.free_valid[i] && !w_ovf)
          r_buf[preg_t'(r_tail + fl_ptr_t'(w_f_pre[i]))] <= fl.free_preg[i];
      if (!w_ovf) r_tail <= r_tail + fl_ptr_t'(w_f_n);
      r_arch_head <= w_arch_nxt;
      r_spec_head <= fl.flush ? w_arch_nxt : w_fire ? r_spec_head + fl_ptr_t'(w_a_n) : r_spec_head;
      r_err       <= r_err | w_ovf | w_cerr;
    end
  end
endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// tb_preg_free_list_ctrl: scoreboard bench for the preg free list against a queue model
module tb_preg_free_list_ctrl;
  import preg_free_list_ctrl_pkg::*;

  typedef struct {
    logic       rdy;
    int         fc;
    logic       err;
    logic [3:0] req;
    int         preg [4];
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  preg_free_list_ctrl_if fl_if ();
  preg_free_list_ctrl dut (.clk(clk), .rst(rst), .fl(fl_if.slave));

  exp_t exp_q [$];
  int   mq [$];
  int   spec_off;
  logic m_err;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    exp_q.delete();
    mq.delete();
    for (int k = NUM_AREGS; k < NUM_PREGS; k++) mq.push_back(k);
    spec_off = 0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fl_if.alloc_req = '0;
    fl_if.free_valid = '0;
    fl_if.free_preg = '0;
    fl_if.commit_alloc_cnt = '0;
    fl_if.flush = 1'b0;
    model_init();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives one cycle of stimulus, queues what the list must show, and advances the model.
  task automatic drive(input logic [3:0] req, input logic [3:0] fv, input logic [3:0][6:0] fp,
                       input int cnt, input logic fl);
    exp_t e;
    int n, k, c;
    fl_if.alloc_req = req;
    fl_if.free_valid = fv;
    fl_if.free_preg = fp;
    fl_if.commit_alloc_cnt = 3'(cnt);
    fl_if.flush = fl;
    n = $countones(req);
    e.fc = mq.size() - spec_off;
    e.err = m_err;
    e.req = req;
    e.rdy = !fl && (e.fc >= n);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      e.preg[i] = -1;
      if (req[i]) begin
        if (spec_off + k < mq.size()) e.preg[i] = mq[spec_off + k];
        k++;
      end
    end
    exp_q.push_back(e);
    c = (cnt > spec_off) ? spec_off : cnt;
    if (cnt > spec_off) m_err = 1'b1;
    if (e.rdy && n != 0) spec_off += n;
    repeat (c) void'(mq.pop_front());
    spec_off = fl ? 0 : spec_off - c;
    if (e.fc == NUM_PREGS && fv != 0) m_err = 1'b1;
    else for (int i = 0; i < 4; i++) if (fv[i]) mq.push_back(int'(fp[i]));
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    drive(4'b0, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc)) begin
      n_fail++; $display("FAIL reset_free_count: got %0d expected %0d", fl_if.free_count, e.fc);
    end
    n_chk++;
    if (fl_if.alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %0b expected 1", fl_if.alloc_ready);
    end
    n_chk++;
    if (fl_if.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %0b expected 0", fl_if.err);
    end
    tick();
  endtask

  task automatic test_alloc4();
    exp_t e;
    do_reset();
    drive(4'b1111, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.alloc_ready !== e.rdy) begin
      n_fail++; $display("FAIL alloc4_ready: got %0b expected %0b", fl_if.alloc_ready, e.rdy);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (fl_if.alloc_preg[i] !== preg_t'(e.preg[i])) begin
        n_fail++; $display("FAIL alloc4_lane%0d: got %0d expected %0d", i, fl_if.alloc_preg[i], e.preg[i]);
      end
    end
    tick();
    drive(4'b0, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc)) begin
      n_fail++; $display("FAIL alloc4_free_count: got %0d expected %0d", fl_if.free_count, e.fc);
    end
    tick();
  endtask

  task automatic test_sparse();
    exp_t e;
    do_reset();
    drive(4'b1010, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    for (int i = 1; i < 4; i += 2) begin
      n_chk++;
      if (fl_if.alloc_preg[i] !== preg_t'(e.preg[i])) begin
        n_fail++; $display("FAIL sparse_lane%0d: got %0d expected %0d", i, fl_if.alloc_preg[i], e.preg[i]);
      end
    end
    tick();
    drive(4'b0, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc)) begin
      n_fail++; $display("FAIL sparse_free_count: got %0d expected %0d", fl_if.free_count, e.fc);
    end
    tick();
  endtask

  task automatic test_drain();
    exp_t e;
    logic [3:0][6:0] fp;
    logic [3:0] reqs [6] = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0000, 4'b0001};
    logic [3:0] fvs  [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 23; c++) begin
      drive(4'b1111, 4'b0, '0, 0, 1'b0);
      tick();
      void'(exp_q.pop_front());
    end
    drive(4'b0011, 4'b0, '0, 0, 1'b0);
    tick();
    void'(exp_q.pop_front());
    fp = '0;
    fp[0] = 7'd7;
    // short of space, stall, free preg 7, retry, drain to empty, then probe empty
    for (int s = 0; s < 6; s++) begin
      drive(reqs[s], fvs[s], fp, 0, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (fl_if.alloc_ready !== e.rdy) begin
        n_fail++; $display("FAIL drain_ready_s%0d: got %0b expected %0b", s, fl_if.alloc_ready, e.rdy);
      end
      n_chk++;
      if (fl_if.free_count !== 8'(e.fc)) begin
        n_fail++; $display("FAIL drain_free_count_s%0d: got %0d expected %0d", s, fl_if.free_count, e.fc);
      end
      if (e.rdy && e.req[2]) begin
        n_chk++;
        if (fl_if.alloc_preg[2] !== preg_t'(e.preg[2])) begin
          n_fail++; $display("FAIL drain_lane2: got %0d expected %0d", fl_if.alloc_preg[2], e.preg[2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    drive(4'b1111, 4'b0, '0, 0, 1'b0); tick();
    drive(4'b1111, 4'b0, '0, 1, 1'b0); tick();
    drive(4'b0000, 4'b0, '0, 1, 1'b0); tick();
    drive(4'b0000, 4'b0, '0, 1, 1'b0); tick();
    repeat (4) void'(exp_q.pop_front());
    drive(4'b1111, 4'b0, '0, 0, 1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got %0b expected 0", fl_if.alloc_ready);
    end
    tick();
    drive(4'b0001, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc)) begin
      n_fail++; $display("FAIL flush_free_count: got %0d expected %0d", fl_if.free_count, e.fc);
    end
    n_chk++;
    if (fl_if.alloc_preg[0] !== preg_t'(e.preg[0])) begin
      n_fail++; $display("FAIL flush_reissue: got %0d expected %0d", fl_if.alloc_preg[0], e.preg[0]);
    end
    tick();
    drive(4'b0, 4'b0, '0, 1, 1'b0);
    tick();
    void'(exp_q.pop_front());
    drive(4'b0, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.err !== e.err) begin
      n_fail++; $display("FAIL flush_err: got %0b expected %0b", fl_if.err, e.err);
    end
    tick();
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [3:0][6:0] fp;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 4; i++) fp[i] = 7'($urandom_range(NUM_PREGS - 1));
      drive(4'b1111, 4'b1111, fp, (c == 0) ? 0 : 4, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (fl_if.alloc_ready !== e.rdy || fl_if.free_count !== 8'(e.fc)) begin
        n_fail++; $display("FAIL wrap_c%0d_ready_count: got %0b/%0d expected %0b/%0d",
                           c, fl_if.alloc_ready, fl_if.free_count, e.rdy, e.fc);
      end
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (fl_if.alloc_preg[i] !== preg_t'(e.preg[i])) begin
          n_fail++; $display("FAIL wrap_c%0d_lane%0d: got %0d expected %0d", c, i, fl_if.alloc_preg[i], e.preg[i]);
        end
      end
      tick();
    end
    drive(4'b0, 4'b0, '0, 4, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.err !== 1'b0 || e.err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_err: got %0b expected 0", fl_if.err);
    end
    tick();
  endtask

  task automatic test_commit_err();
    exp_t e;
    do_reset();
    drive(4'b0, 4'b0, '0, 2, 1'b0);
    tick();
    void'(exp_q.pop_front());
    drive(4'b0001, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.err !== e.err) begin
      n_fail++; $display("FAIL commit_err: got %0b expected %0b", fl_if.err, e.err);
    end
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc) || fl_if.alloc_preg[0] !== preg_t'(e.preg[0])) begin
      n_fail++; $display("FAIL commit_err_state: got %0d/%0d expected %0d/%0d",
                         fl_if.free_count, fl_if.alloc_preg[0], e.fc, e.preg[0]);
    end
    tick();
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [3:0][6:0] fp;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) fp[i] = 7'($urandom_range(NUM_PREGS - 1));
      drive(4'b0, 4'b1111, fp, 0, 1'b0);
      tick();
      void'(exp_q.pop_front());
    end
    drive(4'b0, 4'b0001, fp, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc) || fl_if.err !== e.err) begin
      n_fail++; $display("FAIL full_state: got %0d/%0b expected %0d/%0b", fl_if.free_count, fl_if.err, e.fc, e.err);
    end
    tick();
    drive(4'b0, 4'b0, '0, 0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (fl_if.err !== e.err) begin
      n_fail++; $display("FAIL overflow_err: got %0b expected %0b", fl_if.err, e.err);
    end
    n_chk++;
    if (fl_if.free_count !== 8'(e.fc)) begin
      n_fail++; $display("FAIL overflow_count: got %0d expected %0d", fl_if.free_count, e.fc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b1111, 4'b0, '0, 3, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (fl_if.free_count !== 8'(NUM_PREGS - NUM_AREGS)) begin
      n_fail++; $display("FAIL reset_mid_count: got %0d expected %0d", fl_if.free_count, NUM_PREGS - NUM_AREGS);
    end
    n_chk++;
    if (fl_if.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_err: got %0b expected 0", fl_if.err);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alloc4();
    test_sparse();
    test_drain();
    test_flush();
    test_wrap();
    test_commit_err();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
